// File: rtl/fetch_sequencer_pkg.sv
// Shared widths, opcodes, instruction layout and FSM states for the 8-puzzle
// solver core's fetch/issue stage.
package fetch_sequencer_pkg;

   localparam int OPC_W    = 5;
   localparam int PC_W     = 6;
   localparam int INSTR_W  = 16;
   localparam int ICOUNT_W = 16;

   typedef logic [OPC_W-1:0]    opcode_t;
   typedef logic [PC_W-1:0]     pc_t;
   typedef logic [INSTR_W-1:0]  instr_t;
   typedef logic [ICOUNT_W-1:0] icount_t;

   // Opcode map; only JMP and JNZ are resolved in fetch, the rest go to execute.
   localparam opcode_t OPC_JMP   = 5'd0;
   localparam opcode_t OPC_JNZ   = 5'd1;
   localparam opcode_t OPC_COPY  = 5'd2;
   localparam opcode_t OPC_CHECK = 5'd3;
   localparam opcode_t OPC_SWAP  = 5'd4;
   localparam opcode_t OPC_PUSH  = 5'd5;
   localparam opcode_t OPC_POP   = 5'd6;
   localparam opcode_t OPC_CMP   = 5'd7;

   localparam pc_t START_PC_DEF = 6'd0;
   localparam pc_t FIN_PC_DEF   = 6'd38;

   // op[15:11] opcode, op[10:6] operand bits owned by execute, op[5:0] jump target.
   typedef struct packed {
      opcode_t    opcode;
      logic [4:0] operand;
      pc_t        target;
   } instr_fields_t;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      EXEC,
      WAIT,
      HALT
   } state_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// ROM fetch bus and execute-stage issue handshake of the fetch sequencer.
interface fetch_sequencer_if;
   import fetch_sequencer_pkg::*;

   pc_t    pc;
   instr_t op;
   logic   ex_valid;
   instr_t ex_op;
   logic   ex_ready;
   logic   ex_done;
   logic   ex_flag;

   modport master (
      output pc, ex_valid, ex_op,
      input  op, ex_ready, ex_done, ex_flag
   );

   modport slave (
      input  pc, ex_valid, ex_op,
      output op, ex_ready, ex_done, ex_flag
   );

endinterface

// File: rtl/fetch_sequencer_retire_counter.sv
// Saturating up-counter with synchronous clear; shared by the retire and
// search-depth statistics.
module retire_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Program counter and issue stage: fetches from the instruction ROM, resolves
// JMP/JNZ locally and hands all other instructions to execute one at a time.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter opcode_t OP_JMP   = OPC_JMP,
   parameter opcode_t OP_JNZ   = OPC_JNZ,
   parameter pc_t     START_PC = START_PC_DEF,
   parameter pc_t     FIN_PC   = FIN_PC_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   fetch_sequencer_if.master   bus,
   output logic                busy,
   output logic                halted,
   output icount_t             icount
);

   state_t        state;
   state_t        state_nxt;
   pc_t           pc_q;
   instr_fields_t op_q;
   logic          flag_q;

   logic is_jmp;
   logic is_jnz;
   logic is_jump;
   logic start_ok;
   logic retire;

   assign is_jmp   = (op_q.opcode == OP_JMP);
   assign is_jnz   = (op_q.opcode == OP_JNZ);
   assign is_jump  = is_jmp || is_jnz;
   assign start_ok = start && ((state == IDLE) || (state == HALT));
   assign retire   = ((state == EXEC) && is_jump) || ((state == WAIT) && bus.ex_done);

   assign bus.pc    = pc_q;
   assign bus.ex_op = op_q;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      // NOTE: default assignment first keeps this block free of inferred latches.
      state_nxt = state;
      case (state)
         IDLE, HALT: begin
            if (start) state_nxt = FETCH;
         end
         FETCH: begin
            state_nxt = (pc_q == FIN_PC) ? HALT : EXEC;
         end
         EXEC: begin
            if (is_jump)           state_nxt = FETCH;
            else if (bus.ex_ready) state_nxt = WAIT;
         end
         WAIT: begin
            if (bus.ex_done) state_nxt = FETCH;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Moore outputs: ex_valid depends only on state and the registered word.
   always_comb begin
      bus.ex_valid = (state == EXEC) && !is_jump;
      busy         = (state == FETCH) || (state == EXEC) || (state == WAIT);
      halted       = (state == HALT);
   end

   // The word at FIN_PC is never captured, so ex_op keeps the last real instruction.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q   <= '0;
         op_q   <= '0;
         flag_q <= 1'b0;
      end else begin
         case (state)
            IDLE, HALT: begin
               if (start) begin
                  pc_q   <= START_PC;
                  flag_q <= 1'b0;
               end
            end
            FETCH: begin
               if (pc_q != FIN_PC) op_q <= bus.op;
            end
            EXEC: begin
               if (is_jmp) begin
                  pc_q <= op_q.target;
               end else if (is_jnz) begin
                  pc_q <= flag_q ? op_q.target : pc_q + pc_t'(1);
               end
            end
            WAIT: begin
               if (bus.ex_done) begin
                  flag_q <= bus.ex_flag;
                  pc_q   <= pc_q + pc_t'(1);
               end
            end
            default: ;
         endcase
      end
   end

   retire_counter #(
      .W (ICOUNT_W)
   ) u_retire (
      .clk   (clk),
      .rst   (rst),
      .clr   (start_ok),
      .inc   (retire),
      .count (icount)
   );

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: small ROM programs, an execute responder
// that completes on the first WAIT cycle, and hand-computed expectations.
module tb_fetch_sequencer;
   import fetch_sequencer_pkg::*;

   logic    clk = 1'b0;
   logic    rst;
   logic    start;
   logic    busy;
   logic    halted;
   icount_t icount;

   logic [15:0] rom [64];

   fetch_sequencer_if bus ();
   assign bus.op = rom[bus.pc];

   fetch_sequencer dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .bus    (bus),
      .busy   (busy),
      .halted (halted),
      .icount (icount)
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_errors = 0;
   logic auto_en;
   logic man_done;
   logic flag_val;
   logic hs_pending;
   int   issued[$];
   int   exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] mk(input opcode_t opc, input logic [5:0] tgt);
      return {opc, 5'd0, tgt};
   endfunction

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic go();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   // Runs from the current FETCH until halted, logging the pc of each issue.
   task automatic run_check(input string tag, input int exp_cyc, input int exp_icount);
      int cyc;
      cyc = 0;
      issued.delete();
      while (!halted && cyc < 300) begin
         if (bus.ex_valid && bus.ex_ready) issued.push_back(int'(bus.pc));
         cycle();
         cyc++;
      end
      check({tag, "_halted"}, 32'(halted), 32'd1);
      check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      check({tag, "_icount"}, 32'(icount), 32'(exp_icount));
      check({tag, "_n_issued"}, 32'(issued.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < issued.size(); i++)
         check({tag, "_issued_pc"}, 32'(issued[i]), 32'(exp_q[i]));
   endtask

   // Execute-side model: completes each accepted instruction on the first WAIT cycle.
   initial begin
      hs_pending  = 1'b0;
      bus.ex_done = 1'b0;
      bus.ex_flag = 1'b0;
      forever begin
         @(posedge clk);
         #2;
         bus.ex_done = auto_en ? hs_pending : man_done;
         bus.ex_flag = bus.ex_done ? flag_val : 1'b0;
         hs_pending  = bus.ex_valid && bus.ex_ready;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst          = 1'b1;
      start        = 1'b0;
      bus.ex_ready = 1'b1;
      auto_en      = 1'b1;
      man_done     = 1'b0;
      flag_val     = 1'b0;
      for (int i = 0; i < 64; i++) rom[i] = mk(OPC_COPY, 6'(i));
      rom[38] = 16'hDEAD;
      rom[4]  = mk(OPC_JMP, 6'd38);

      cycle();
      cycle();
      check("rst_pc", 32'(bus.pc), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_ex_valid", 32'(bus.ex_valid), 32'd0);
      check("rst_ex_op", 32'(bus.ex_op), 32'd0);
      check("rst_icount", 32'(icount), 32'd0);
      rst = 1'b0;
      cycle();
      check("idle_busy", 32'(busy), 32'd0);

      // Straight line 0..3, then JMP 38 at 4.
      go();
      check("sl_fetch_pc", 32'(bus.pc), 32'd0);
      check("sl_fetch_busy", 32'(busy), 32'd1);
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("sl_exec_valid", 32'(bus.ex_valid), 32'd1);
         check("sl_exec_pc", 32'(bus.pc), 32'(k));
         check("sl_exec_op", 32'(bus.ex_op), 32'(mk(OPC_COPY, 6'(k))));
         cycle();
         check("sl_wait_valid", 32'(bus.ex_valid), 32'd0);
         cycle();
         check("sl_next_pc", 32'(bus.pc), 32'(k + 1));
         check("sl_icount", 32'(icount), 32'(k + 1));
      end
      cycle();
      check("sl_jmp_no_valid", 32'(bus.ex_valid), 32'd0);
      cycle();
      check("sl_jmp_pc", 32'(bus.pc), 32'd38);
      check("sl_jmp_icount", 32'(icount), 32'd5);
      cycle();
      check("fin_halted", 32'(halted), 32'd1);
      check("fin_busy", 32'(busy), 32'd0);
      check("fin_ex_valid", 32'(bus.ex_valid), 32'd0);
      check("fin_op_not_taken", 32'(bus.ex_op), 32'(mk(OPC_JMP, 6'd38)));

      // Restart from HALT clears icount and reruns the same program.
      go();
      check("restart_pc", 32'(bus.pc), 32'd0);
      check("restart_icount", 32'(icount), 32'd0);
      check("restart_halted", 32'(halted), 32'd0);
      exp_q = {0, 1, 2, 3};
      run_check("rerun", 15, 5);

      // JMP at 5 to 12; 5 must never be offered to execute.
      rom[4]  = mk(OPC_COPY, 6'd4);
      rom[5]  = mk(OPC_JMP, 6'd12);
      rom[13] = mk(OPC_JMP, 6'd38);
      go();
      exp_q = {0, 1, 2, 3, 4, 12};
      run_check("jmp", 23, 8);

      // JNZ taken after CHECK returns flag=1.
      flag_val = 1'b1;
      rom[1]  = mk(OPC_CHECK, 6'd0);
      rom[2]  = mk(OPC_JNZ, 6'd24);
      rom[4]  = mk(OPC_JMP, 6'd38);
      rom[25] = mk(OPC_JMP, 6'd38);
      go();
      exp_q = {0, 1, 24};
      run_check("jnz_taken", 14, 5);

      // Start clears flag (JNZ at 0 falls through), CHECK returns 0, JNZ at 2 falls through.
      flag_val = 1'b0;
      rom[0]  = mk(OPC_JNZ, 6'd30);
      rom[30] = mk(OPC_JMP, 6'd38);
      go();
      exp_q = {1, 3};
      run_check("jnz_not_taken", 13, 5);

      // pc wraps 63 -> 0; the flag from 63 survives the intervening jumps.
      flag_val = 1'b1;
      rom[0]  = mk(OPC_JNZ, 6'd10);
      rom[1]  = mk(OPC_JMP, 6'd63);
      rom[63] = mk(OPC_CHECK, 6'd0);
      rom[10] = mk(OPC_JMP, 6'd38);
      go();
      exp_q = {63};
      run_check("wrap", 12, 5);

      // ex_ready held low for three EXEC edges.
      flag_val     = 1'b0;
      rom[0]       = mk(OPC_COPY, 6'd0);
      rom[1]       = mk(OPC_JMP, 6'd38);
      bus.ex_ready = 1'b0;
      go();
      for (int k = 0; k < 4; k++) begin
         cycle();
         check("stall_valid", 32'(bus.ex_valid), 32'd1);
         check("stall_op", 32'(bus.ex_op), 32'(mk(OPC_COPY, 6'd0)));
      end
      bus.ex_ready = 1'b1;
      cycle();
      check("stall_wait_valid", 32'(bus.ex_valid), 32'd0);
      check("stall_wait_busy", 32'(busy), 32'd1);
      cycle();
      check("stall_next_pc", 32'(bus.pc), 32'd1);
      check("stall_icount", 32'(icount), 32'd1);
      exp_q = {};
      run_check("stall_tail", 3, 2);

      // Reset while waiting on execute at pc 17.
      auto_en = 1'b0;
      rom[0]  = mk(OPC_JMP, 6'd17);
      rom[18] = mk(OPC_JMP, 6'd38);
      go();
      cycle();
      cycle();
      check("rw_fetch_pc", 32'(bus.pc), 32'd17);
      cycle();
      cycle();
      check("rw_wait_pc", 32'(bus.pc), 32'd17);
      check("rw_wait_valid", 32'(bus.ex_valid), 32'd0);
      check("rw_wait_icount", 32'(icount), 32'd1);
      start = 1'b1;
      cycle();
      start = 1'b0;
      check("busy_start_pc", 32'(bus.pc), 32'd17);
      check("busy_start_icount", 32'(icount), 32'd1);
      check("busy_start_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      check("rw_rst_pc", 32'(bus.pc), 32'd0);
      check("rw_rst_busy", 32'(busy), 32'd0);
      check("rw_rst_icount", 32'(icount), 32'd0);
      check("rw_rst_ex_op", 32'(bus.ex_op), 32'd0);
      man_done = 1'b1;
      cycle();
      man_done = 1'b0;
      cycle();
      check("late_done_pc", 32'(bus.pc), 32'd0);
      check("late_done_icount", 32'(icount), 32'd0);
      check("late_done_busy", 32'(busy), 32'd0);

      auto_en = 1'b1;
      cycle();
      go();
      exp_q = {17};
      run_check("after_reset", 8, 3);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
